// File: rtl/logic_result_fifo.sv
// Registered result FIFO behind the 32-bit bitwise logic units: captures each result
// together with its zero/negative flags and replays them in order over valid/ready.
module logic_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             drop_err
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_err_q, drop_err_d;
    logic          push, pop;

    // Both handshake outputs come only from count_q, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_err_d = drop_err_q | (in_valid & ~in_ready);

        // DEPTH is a power of two, so the pointers wrap simply by overflowing AW bits.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{data: in_data,
                                 zero: (in_data == '0),
                                 neg:  in_data[WIDTH-1]};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head.data : '0;
    assign out_zero = out_valid ? head.zero : 1'b0;
    assign out_neg  = out_valid ? head.neg  : 1'b0;
    assign count    = count_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_logic_result_fifo.sv
// Self-checking bench for logic_result_fifo: a queue scoreboard holds the expected
// results in order, with one task per scenario.
module tb_logic_result_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             drop_err;

    logic [WIDTH-1:0] sb[$];
    logic             exp_drop;
    int               checks = 0;
    int               errors = 0;
    int               popped = 0;

    logic_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    // One clock edge: check handshake state and any popped head against the scoreboard
    // before the edge, update the model, then advance to just after the edge.
    task automatic step();
        bit push_ok, pop_ok;
        logic [WIDTH-1:0] exp_d;
        push_ok = in_valid && (sb.size() != DEPTH);
        pop_ok  = out_ready && (sb.size() != 0);
        checks++;
        if (in_ready !== (sb.size() != DEPTH)) begin
            errors++;
            $display("FAIL in_ready got %b want %b", in_ready, sb.size() != DEPTH);
        end
        checks++;
        if (out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL out_valid got %b want %b", out_valid, sb.size() != 0);
        end
        checks++;
        if (count !== CW'(sb.size())) begin
            errors++;
            $display("FAIL count got %0d want %0d", count, sb.size());
        end
        if (pop_ok) begin
            exp_d = sb.pop_front();
            popped++;
            checks++;
            if (out_data !== exp_d || out_zero !== (exp_d == '0) || out_neg !== exp_d[WIDTH-1]) begin
                errors++;
                $display("FAIL pop_head got %h z%b n%b want %h z%b n%b",
                         out_data, out_zero, out_neg, exp_d, exp_d == '0, exp_d[WIDTH-1]);
            end
        end
        if (push_ok) sb.push_back(in_data);
        if (in_valid && !push_ok) exp_drop = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (drop_err !== exp_drop) begin
            errors++;
            $display("FAIL drop_err got %b want %b", drop_err, exp_drop);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_drop  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_err !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state got cnt%0d ov%b ir%b de%b d%h want cnt0 ov0 ir1 de0 d0",
                     count, out_valid, in_ready, drop_err, out_data);
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);
        checks++;
        if (out_data !== '0 || out_zero !== 1'b0 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs got d%h z%b n%b want 0 0 0", out_data, out_zero, out_neg);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h0000_000B, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_000B || out_zero !== 1'b0 ||
            out_neg !== 1'b0 || count !== CW'(1)) begin
            errors++;
            $display("FAIL single_pass got ov%b d%h z%b n%b cnt%0d want ov1 d0000000b z0 n0 cnt1",
                     out_valid, out_data, out_zero, out_neg, count);
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_flags();
        drive(1'b1, 32'h0000_0000, 1'b0);
        drive(1'b1, 32'h8000_0000, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_zero !== 1'b1 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL zero_head got z%b n%b want z1 n0", out_zero, out_neg);
        end
        drive(1'b0, '0, 1'b1);
        checks++;
        if (out_zero !== 1'b0 || out_neg !== 1'b1 || out_data !== 32'h8000_0000) begin
            errors++;
            $display("FAIL neg_head got d%h z%b n%b want 80000000 z0 n1", out_data, out_zero, out_neg);
        end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) drive(1'b1, WIDTH'(i), 1'b0);
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(4) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got cnt%0d ir%b want cnt4 ir0", count, in_ready);
        end
        drive(1'b1, 32'd5, 1'b0);
        checks++;
        if (drop_err !== 1'b1 || count !== CW'(4)) begin
            errors++;
            $display("FAIL overflow got de%b cnt%0d want de1 cnt4", drop_err, count);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== '0) begin
            errors++;
            $display("FAIL drained got ov%b d%h cnt%0d want ov0 d0 cnt0", out_valid, out_data, count);
        end
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = popped;
        drive(1'b1, 32'hA000_0001, 1'b0);
        drive(1'b1, 32'h0000_0002, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, WIDTH'(32'h5A00_0000 + i * 32'h0101_0101), 1'b1);
            checks++;
            if (count !== CW'(2)) begin
                errors++;
                $display("FAIL stream_count iter %0d got %0d want 2", i, count);
            end
        end
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        checks++;
        if (popped - start_pops != 12 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_total got %0d pops ov%b want 12 pops ov0", popped - start_pops, out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0000_0011, 1'b0);
        drive(1'b1, 32'h0000_0022, 1'b0);
        drive(1'b1, 32'h0000_0033, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || drop_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got cnt%0d ov%b de%b ir%b want cnt0 ov0 de0 ir1",
                     count, out_valid, drop_err, in_ready);
        end
        sb.delete();
        exp_drop = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'd7, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd7 || count !== CW'(1)) begin
            errors++;
            $display("FAIL post_reset_head got ov%b d%h cnt%0d want ov1 d00000007 cnt1",
                     out_valid, out_data, count);
        end
        drive(1'b0, '0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
